// File: rtl/pipe_adder_pkg.sv
// Shared types and constants for the pipelined carry-chunk adder.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Operand B is forwarded through a flat chain of shrinking slices: stage k
  // still owns WIDTH - k*cw bits (its own chunk plus everything above it).
  // This returns the bit offset of stage k's slice inside that chain.
  function automatic int rem_off(input int width, input int cw, input int k);
    return k * width - (cw * k * (k - 1)) / 2;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational chunk adder: one carry-chain segment of the pipelined adder.
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub with valid/ready handshake. Each stage resolves one
// WIDTH/STAGES chunk and registers the carry for the next stage.
// Optional build macro: PIPE_ADDER_SAT_EN clamps the result to signed
// max/min on overflow; without it the result wraps.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int BTOT = rem_off(WIDTH, CW, STAGES);

  logic                          adv;
  mode_e                         mode;
  logic [STAGES:1]               vld_pipe;
  // a_i[k]: finished sum chunks below k*CW, untouched operand A above.
  logic [STAGES-1:0][WIDTH-1:0]  a_i;
  logic [STAGES-1:0]             c_i;
  logic [BTOT-1:0]               b_chain;
  logic [WIDTH-1:0]              sum_q;
  flags_t                        flags_q;

  assign mode      = in_sub ? SUB : ADD;
  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Subtract is A + ~B + ~borrow; fold the inversion in before stage 0.
  assign a_i[0]             = in_a;
  assign b_chain[WIDTH-1:0] = (mode == SUB) ? ~in_b : in_b;
  assign c_i[0]             = (mode == SUB) ? ~in_cin : in_cin;

  assign out_sum  = sum_q;
  assign out_cout = flags_q.cout;
  assign out_ovf  = flags_q.ovf;
  assign out_zero = flags_q.zero;

  // Valid bits shift with the pipeline; bubbles travel as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BOFF = rem_off(WIDTH, CW, k);
    localparam int BW   = WIDTH - k * CW;

    logic [BW-1:0]    b_rem;
    logic [CW-1:0]    chunk;
    logic             carry;
    logic [WIDTH-1:0] s_nxt;

    assign b_rem = b_chain[BOFF +: BW];

    adder_slice #(.W(CW)) u_slice (
      .a    (a_i[k][k*CW +: CW]),
      .b    (b_rem[CW-1:0]),
      .cin  (c_i[k]),
      .sum  (chunk),
      .cout (carry)
    );

    // Replace operand chunk k with its resolved sum chunk.
    always_comb begin
      s_nxt = a_i[k];
      s_nxt[k*CW +: CW] = chunk;
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int BOFF_N = rem_off(WIDTH, CW, k + 1);

      logic [WIDTH-1:0]   a_q;
      logic [BW-CW-1:0]   b_q;
      logic               c_q;

      // Stage register: partial sum + pending A, pending B', chunk carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= s_nxt;
          b_q <= b_rem[BW-1:CW];
          c_q <= carry;
        end
      end

      assign a_i[k+1]                     = a_q;
      assign b_chain[BOFF_N +: BW-CW]     = b_q;
      assign c_i[k+1]                     = c_q;
    end else begin : g_out
      logic             ovf;
      logic [WIDTH-1:0] res;

      // Top chunk of a_i still holds A's sign; b_rem's MSB is B' sign.
      assign ovf = (a_i[k][WIDTH-1] == b_rem[CW-1]) &&
                   (s_nxt[WIDTH-1] != a_i[k][WIDTH-1]);

`ifdef PIPE_ADDER_SAT_EN
      assign res = !ovf            ? s_nxt :
                   a_i[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res = s_nxt;
`endif

      // Output register: final sum and flags, held while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q   <= '0;
          flags_q <= '0;
        end else if (adv) begin
          sum_q        <= res;
          flags_q.cout <= carry;
          flags_q.ovf  <= ovf;
          flags_q.zero <= (res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=2): directed table,
// latency/reset sequences, and random traffic against an arithmetic model.
module tb_pipe_adder;

  localparam int W = 32;
  localparam int S = 2;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, out_zero;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    res_t        exp;
  } vec_t;

  res_t sb[$];
  res_t cur_exp;
  res_t held;
  logic stall_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  // Reference: integer arithmetic on the operands' numeric values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb_ = longint'($signed(b));
    longint u, s;
    if (!sub) begin
      u = ua + ub + longint'(cin);
      s = sa + sb_ + longint'(cin);
      r.cout = (u > 64'sd4294967295);
    end else begin
      u = ua - ub - longint'(cin);
      s = sa - sb_ - longint'(cin);
      r.cout = (u >= 0);
    end
    r.sum = u[31:0];
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    if (SAT && r.ovf) r.sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub,
                              input logic [31:0] sum, input logic cout,
                              input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp.sum = sum; v.exp.cout = cout; v.exp.ovf = ovf; v.exp.zero = zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: evaluate handshakes just after the falling edge, then advance.
  task automatic cyc(output logic acc);
    res_t e;
    #1;
    acc = in_valid && in_ready;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(out_sum), 64'(held.sum));
      chk("stall_flags", 64'({out_cout, out_ovf, out_zero}),
          64'({held.cout, held.ovf, held.zero}));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sum %0h with no beat outstanding", out_sum);
      end else begin
        e = sb.pop_front();
        chk("sum", 64'(out_sum), 64'(e.sum));
        chk("flags", 64'({out_cout, out_ovf, out_zero}), 64'({e.cout, e.ovf, e.zero}));
      end
    end
    if (acc) sb.push_back(cur_exp);
    stall_prev = out_valid && !out_ready;
    held.sum = out_sum; held.cout = out_cout; held.ovf = out_ovf; held.zero = out_zero;
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input res_t e, input bit rnd);
    logic acc;
    int   n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; cur_exp = e;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic drain(input bit rnd);
    logic acc;
    int   n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(acc);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        acc;
    logic [31:0] ra, rb;
    logic        rc, rs;

    vecs[0] = mk(32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0, 0);
    vecs[1] = mk(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1);
    vecs[2] = mk(32'h7FFF_FFFF, 32'h1, 0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1, 0);
    vecs[3] = mk(32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    vecs[4] = mk(32'd7, 32'd5, 0, 1, 32'h2, 1, 0, 0);
    vecs[5] = mk(32'h8000_0000, 32'h1, 0, 1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1, 0);
    vecs[6] = mk(32'h0000_FFFF, 32'h0, 1, 0, 32'h0001_0000, 0, 0, 0);
    vecs[7] = mk(32'd5, 32'd5, 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    vecs[8] = mk(32'd5, 32'd5, 0, 1, 32'h0, 1, 0, 1);
    vecs[9] = mk(32'h8000_0000, 32'h8000_0000, 0, 0, SAT ? 32'h8000_0000 : 32'h0, 1, 1, !SAT);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: accepted beat appears exactly two edges later
    out_ready = 1'b1;
    in_a = vecs[0].a; in_b = vecs[0].b; in_cin = vecs[0].cin; in_sub = vecs[0].sub;
    cur_exp = vecs[0].exp;
    in_valid = 1'b1;
    cyc(acc);
    chk("lat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    #1 chk("lat_edge1_valid", 64'(out_valid), 64'd0);
    cyc(acc);
    #1 chk("lat_edge2_valid", 64'(out_valid), 64'd1);
    cyc(acc);
    chk("lat_popped", 64'(sb.size()), 64'd0);

    // Directed table, back to back
    for (int i = 0; i < 10; i++)
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp, 1'b0);
    drain(1'b0);

    // Random traffic with 50% out_ready; first 10 beats strictly back to back
    for (int i = 0; i < 60; i++) begin
      if (i >= 10 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        cyc(acc);
      end
      ra = pick(); rb = pick();
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
    end
    drain(1'b1);

    // Reset with two beats in flight
    out_ready = 1'b1;
    drive(32'd1, 32'd2, 0, 0, model(32'd1, 32'd2, 0, 0), 1'b0);
    drive(32'd3, 32'd4, 0, 0, model(32'd3, 32'd4, 0, 0), 1'b0);
    in_valid = 1'b0;
    #1 chk("inflight_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum", 64'(out_sum), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("post_rst_quiet", 64'(out_valid), 64'd0);
      cyc(acc);
    end
    drive(32'hDEAD_0000, 32'h0000_BEEF, 1, 0, model(32'hDEAD_0000, 32'h0000_BEEF, 1, 0), 1'b0);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 2, pipeline depth: number of carry chunks and cycles of latency (1..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the operand beat this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in (borrow-in when in_sub=1).
REQ-010 in_sub  input  1  0 = A+B+cin; 1 = A-B-cin.
REQ-011 out_valid  output  1  result beat available.
REQ-012 out_ready  input  1  consumer accepts the result beat.
REQ-013 out_sum  output  WIDTH  result.
REQ-014 out_cout  output  1  carry-out (add) / not-borrow (sub).
REQ-015 out_ovf  output  1  signed two's-complement overflow.
REQ-016 out_zero  output  1  out_sum is all zeros.

Function
REQ-017 Add: {cout,sum} = A + B + cin, WIDTH+1 bits. Sub: {cout,sum} = A + ~B + ~cin, so cout=1 means no borrow.
REQ-018 Operands split into STAGES chunks of WIDTH/STAGES bits; stage k adds chunk k with the carry registered from stage k-1; unprocessed upper chunks delayed alongside; finished lower chunks carried forward.
REQ-019 Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
REQ-020 Pipeline advances (adv) when !out_valid || out_ready; in_ready = adv; combinational, no dependence on in_valid.
REQ-021 On !adv all stage registers, valid bits and outputs hold; out_* stable while out_valid && !out_ready.
REQ-022 Latency: beat accepted at cycle N appears on out_* at N+STAGES when no stall; throughput one beat per cycle.
REQ-023 Per-stage valid bit shifts with adv; bubbles (in_valid=0 on adv) propagate as invalid entries.
REQ-024 ovf = (sign A == sign B') && (sign sum != sign A), B' = B or ~B per mode; computed in last stage.
REQ-025 zero evaluated on final out_sum (after saturation when enabled).
REQ-026 Ordering strictly FIFO; no beat dropped or duplicated under any out_ready pattern.
REQ-027 STAGES=1: purely registered single-cycle adder, same handshake.

Reset
REQ-028 rst_n low: all valid bits, out_valid, out_sum, out_cout, out_ovf, out_zero clear to 0 immediately, independent of clk.
REQ-029 In-flight beats discarded on reset; in_ready=1 during reset and after release.
REQ-030 Reset release is synchronous to clk; first acceptance possible on the first rising edge with rst_n high.

Configuration
REQ-031 Macro PIPE_ADDER_SAT_EN defined: on out_ovf=1, out_sum clamps to signed max (0x7FFF_FFFF at WIDTH=32) if A non-negative, else signed min (0x8000_0000); out_ovf still reports 1.
REQ-032 Macro undefined: out_sum wraps modulo 2^WIDTH; no saturation logic present.

Structure
REQ-033 Package pipe_adder_pkg holds mode enum (ADD, SUB), flag struct (cout, ovf, zero) and default WIDTH/STAGES constants.
REQ-034 Sub-module adder_slice: combinational chunk adder (chunk a, chunk b, cin -> chunk sum, cout), instanced STAGES times by generate.

Verification (WIDTH=32, STAGES=2)
REQ-035 A=0x0000FFFF, B=0x00000001, cin=0, add -> sum 0x00010000, cout 0, ovf 0, 2 cycles after accept (cross-chunk carry).
REQ-036 A=0xFFFFFFFF, B=0x00000001, cin=0, add -> sum 0x00000000, cout 1, zero 1, ovf 0.
REQ-037 A=0x7FFFFFFF, B=0x00000001, add -> ovf 1; sum 0x80000000 without macro, 0x7FFFFFFF with PIPE_ADDER_SAT_EN.
REQ-038 A=5, B=7, cin=0, sub -> sum 0xFFFFFFFE, cout 0; A=7, B=5 sub -> sum 2, cout 1.
REQ-039 10 back-to-back beats with out_ready random 50%: results in order, none lost, out_* stable during stall.
REQ-040 rst_n pulsed low with 2 beats in flight: out_valid 0 immediately, no stale beat emitted after release.
